vreg_file: RTL and testbench
============================

Name: vreg_file

Overview:
- Parametrised wide-vector register file for the AES/vector datapath of the RV32 core.
- Successor to the fixed 4x256 file: configurable depth and width, lane-masked writes, and write-to-read bypass.
- Adds a per-register pending scoreboard for multi-cycle AES results and a zeroization sequencer for key wipe.
- Single clock domain. Sits between decode (reads), the AES units (reserve) and writeback (writes).

Parameters:
- DATA_W, 256: register width in bits; must be a multiple of LANE_W.
- LANE_W, 32: write-mask granularity in bits.
- NUM_REGS, 8: number of registers; must be a power of two, minimum 2.
- ADDR_W, 5: width of the architectural index ports. Only the low IDX_W bits are used, where IDX_W = $clog2(NUM_REGS).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- RE  in  1  read request.
- A1  in  ADDR_W  read index, port 1.
- A2  in  ADDR_W  read index, port 2.
- RVALID  out  1  RD1/RD2 valid; one cycle after an accepted RE.
- RD1  out  DATA_W  read data, port 1 (registered).
- RD2  out  DATA_W  read data, port 2 (registered).
- RSTALL  out  1  combinational; RE this cycle is refused.
- WE  in  1  write enable.
- A3  in  ADDR_W  write index.
- WMASK  in  DATA_W/LANE_W  lane enables for the write.
- WB  in  DATA_W  write data.
- RSV  in  1  reserve A3 as pending; used by the AES issue stage.
- CLR_REQ  in  1  start zeroization.
- CLR_BUSY  out  1  zeroization sequencer active.
- CLR_DONE  out  1  single-cycle pulse when zeroization completes.
- PERR  out  1  parity error on the last read (VREG_PARITY_EN only).

Behaviour:
- Reset (synchronous, RST=1 at posedge):
  - All registers, pending bits, RD1, RD2 and the clear counter go to 0.
  - RVALID, CLR_BUSY, CLR_DONE and PERR go to 0.
  - FSM goes to IDLE.
  - RST overrides every other input, including mid-clear.
- Read:
  - RSTALL = RE & (CLR_BUSY | pend[A1] | pend[A2]).
  - An accepted read (RE & !RSTALL) latches RD1/RD2 and sets RVALID=1 the next cycle.
  - A refused read sets RVALID=0. RD1/RD2 hold their previous values.
- Read bypass:
  - If an accepted write hits the same index in the same cycle, the read returns the merged value: WB lanes where WMASK=1, old data elsewhere.
  - A1 and A2 may be equal; both ports return identical data.
- Write:
  - When WE=1 and FSM is IDLE, reg[A3] lane i is updated for each WMASK[i]=1.
  - WMASK=0 writes nothing but still clears pend[A3].
  - WE is ignored while CLR_BUSY=1.
- Scoreboard:
  - RSV=1 sets pend[A3]. A write to that index clears it.
  - RSV and WE in the same cycle: the write takes effect and pend[A3] ends at 1 (reserve wins).
- FSM IDLE:
  - CLR_REQ=1 moves to CLEAR with cnt=0.
  - A CLR_REQ arriving with WE in the same cycle: the write completes first, then CLEAR starts.
- FSM CLEAR:
  - CLR_BUSY=1.
  - Each cycle reg[cnt]=0, pend[cnt]=0, cnt++.
  - After index NUM_REGS-1, move to DONE. Duration is exactly NUM_REGS cycles.
  - CLR_REQ is ignored while in CLEAR.
- FSM DONE:
  - CLR_DONE=1 for one cycle, CLR_BUSY=0, then return to IDLE.
- Wrap-around: the counter is IDX_W+1 bits wide so the terminal compare is free of overflow.

Optional Feature:
- Macro: VREG_PARITY_EN.
- When defined:
  - One even-parity bit is stored per lane and updated with the lane (zeroed on clear and reset).
  - On every accepted read, parity is recomputed for both ports.
  - PERR is registered alongside RVALID and is the OR of all lane mismatches.
- When undefined: no parity storage, and PERR is tied to 0.

Decomposition:
- Package vreg_pkg holds:
  - state enum {IDLE, CLEAR, DONE};
  - default width/depth constants;
  - the lane-merge function merge(old, new, mask).
- One sub-module, vreg_bypass: a combinational read mux plus bypass merge, instantiated per read port.

Test Plan:
- Reset, then RE with A1=0, A2=7 -> RVALID=1 next cycle, RD1=RD2=0.
- WE with A3=3, WMASK=8'h01, WB=all 0xA5; then read A1=3 -> RD1 low 32 bits = 0xA5A5A5A5, all upper lanes 0.
- Same cycle: WE to A3=2 with WMASK=8'hFF and RE with A1=2 -> RD1 equals the new WB (bypass verified).
- RSV with A3=5, then RE with A1=5 -> RSTALL=1 and RVALID=0 next cycle; WE to A3=5 -> the following RE is accepted.
- Fill all 8 registers, pulse CLR_REQ -> CLR_BUSY high for exactly 8 cycles; WE during that window is ignored; CLR_DONE pulses once; every register reads 0.
- RST asserted on the 3rd cycle of CLEAR -> next cycle FSM is IDLE, CLR_BUSY=0, all registers 0; with VREG_PARITY_EN, a forced parity-bit flip produces PERR=1 on the read.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared types, default geometry and the lane-merge helper for the vector register file.
package vreg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_DATA_W   = 256;
   localparam int DEF_LANE_W   = 32;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_ADDR_W   = 5;

   // Widest register the merge helper can handle; callers size-cast in and out.
   localparam int MERGE_W = 1024;

   // Takes new_v bits where bit_mask is set and old_v bits elsewhere.
   // bit_mask is the lane mask already expanded to one bit per data bit.
   function automatic logic [MERGE_W-1:0] merge(
      input logic [MERGE_W-1:0] old_v,
      input logic [MERGE_W-1:0] new_v,
      input logic [MERGE_W-1:0] bit_mask
   );
      return (old_v & ~bit_mask) | (new_v & bit_mask);
   endfunction

endpackage

// File: rtl/vreg_file_if.sv
// Read, write, reserve and zeroization signals of the vector register file.
interface vreg_file_if
   import vreg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LANE_W = DEF_LANE_W,
   parameter int ADDR_W = DEF_ADDR_W
) ();

   logic                       RE;
   logic [ADDR_W-1:0]          A1;
   logic [ADDR_W-1:0]          A2;
   logic                       RVALID;
   logic [DATA_W-1:0]          RD1;
   logic [DATA_W-1:0]          RD2;
   logic                       RSTALL;
   logic                       WE;
   logic [ADDR_W-1:0]          A3;
   logic [DATA_W/LANE_W-1:0]   WMASK;
   logic [DATA_W-1:0]          WB;
   logic                       RSV;
   logic                       CLR_REQ;
   logic                       CLR_BUSY;
   logic                       CLR_DONE;
   logic                       PERR;

   modport master (
      output RE, A1, A2, WE, A3, WMASK, WB, RSV, CLR_REQ,
      input  RVALID, RD1, RD2, RSTALL, CLR_BUSY, CLR_DONE, PERR
   );

   modport slave (
      input  RE, A1, A2, WE, A3, WMASK, WB, RSV, CLR_REQ,
      output RVALID, RD1, RD2, RSTALL, CLR_BUSY, CLR_DONE, PERR
   );

endinterface

// File: rtl/vreg_bypass.sv
// One read port: selects the indexed register and merges in a same-cycle write to that index.
module vreg_bypass
   import vreg_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LANE_W   = DEF_LANE_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic [DATA_W-1:0]        regs_in [NUM_REGS],
   input  logic [IDX_W-1:0]         rd_idx,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [DATA_W/LANE_W-1:0] wr_mask,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]        rd_data
);

   localparam int LANES = DATA_W / LANE_W;

   logic [DATA_W-1:0] old_data;
   logic [DATA_W-1:0] mask_bits;
   logic [DATA_W-1:0] merged;

   assign old_data = regs_in[rd_idx];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign mask_bits[gi*LANE_W +: LANE_W] = {LANE_W{wr_mask[gi]}};
      end
   endgenerate

   assign merged  = DATA_W'(merge(MERGE_W'(old_data), MERGE_W'(wr_data), MERGE_W'(mask_bits)));
   assign rd_data = (wr_en && (rd_idx == wr_idx)) ? merged : old_data;

endmodule

// File: rtl/vreg_file.sv
// Wide vector register file: two registered read ports with write bypass, lane-masked writes,
// pending scoreboard and a zeroization sequencer. Optional per-lane parity under VREG_PARITY_EN.
module vreg_file
   import vreg_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LANE_W   = DEF_LANE_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input logic         CLK,
   input logic         RST,
   vreg_file_if.slave  bus
);

   localparam int LANES  = DATA_W / LANE_W;
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int NPORTS = 2;
   localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_REGS - 1);

   logic [DATA_W-1:0]   regs_reg [NUM_REGS];
   logic [NUM_REGS-1:0] pend_reg;
   logic [NUM_REGS-1:0] pend_next;
   state_t              state_reg;
   logic [IDX_W:0]      cnt_reg;
   logic                clr_busy_reg;
   logic                clr_done_reg;
   logic                rvalid_reg;
   logic                perr_reg;
   logic                perr_next;
   logic [DATA_W-1:0]   rd_reg  [NPORTS];
   logic [DATA_W-1:0]   rd_next [NPORTS];
   logic [IDX_W-1:0]    rd_idx  [NPORTS];
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    clr_idx;
   logic [DATA_W-1:0]   wr_bits;
   logic [DATA_W-1:0]   wr_merged;
   logic                clearing;
   logic                wr_acc;
   logic                rstall;
   logic                rd_acc;

   assign rd_idx[0] = bus.A1[IDX_W-1:0];
   assign rd_idx[1] = bus.A2[IDX_W-1:0];
   assign wr_idx    = bus.A3[IDX_W-1:0];
   assign clr_idx   = cnt_reg[IDX_W-1:0];

   genvar gi;
   generate
      // Architectural indices are wider than the file; the upper bits carry no meaning here.
      if (ADDR_W > IDX_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^{bus.A1[ADDR_W-1:IDX_W], bus.A2[ADDR_W-1:IDX_W],
                                   bus.A3[ADDR_W-1:IDX_W]};
      end
   endgenerate

   assign clearing = (state_reg == CLEAR);
   assign wr_acc   = bus.WE & (state_reg == IDLE);
   assign rstall   = bus.RE & (clearing | pend_reg[rd_idx[0]] | pend_reg[rd_idx[1]]);
   assign rd_acc   = bus.RE & ~rstall;

   generate
      for (gi = 0; gi < LANES; gi++) begin : g_wr_lane
         assign wr_bits[gi*LANE_W +: LANE_W] = {LANE_W{bus.WMASK[gi]}};
      end
      for (gi = 0; gi < NPORTS; gi++) begin : g_port
         vreg_bypass #(
            .DATA_W   (DATA_W),
            .LANE_W   (LANE_W),
            .NUM_REGS (NUM_REGS),
            .IDX_W    (IDX_W)
         ) u_bypass (
            .regs_in  (regs_reg),
            .rd_idx   (rd_idx[gi]),
            .wr_en    (wr_acc),
            .wr_idx   (wr_idx),
            .wr_mask  (bus.WMASK),
            .wr_data  (bus.WB),
            .rd_data  (rd_next[gi])
         );
      end
   endgenerate

   assign wr_merged = DATA_W'(merge(MERGE_W'(regs_reg[wr_idx]), MERGE_W'(bus.WB),
                                    MERGE_W'(wr_bits)));

   // A reservation is applied last so it survives a same-cycle write or sweep.
   always_comb begin
      pend_next = pend_reg;
      if (clearing) begin
         pend_next[clr_idx] = 1'b0;
      end
      if (wr_acc) begin
         pend_next[wr_idx] = 1'b0;
      end
      if (bus.RSV) begin
         pend_next[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_reg[r] <= '0;
         end
         pend_reg <= '0;
      end else begin
         if (clearing) begin
            regs_reg[clr_idx] <= '0;
         end else if (wr_acc) begin
            regs_reg[wr_idx] <= wr_merged;
         end
         pend_reg <= pend_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         clr_busy_reg <= 1'b0;
         clr_done_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               clr_done_reg <= 1'b0;
               if (bus.CLR_REQ) begin
                  state_reg    <= CLEAR;
                  cnt_reg      <= '0;
                  clr_busy_reg <= 1'b1;
               end
            end
            CLEAR: begin
               cnt_reg <= cnt_reg + (IDX_W+1)'(1);
               if (cnt_reg == LAST_IDX) begin
                  state_reg    <= DONE;
                  clr_busy_reg <= 1'b0;
                  clr_done_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg    <= IDLE;
               clr_done_reg <= 1'b0;
            end
            default: begin
               state_reg    <= IDLE;
               clr_busy_reg <= 1'b0;
               clr_done_reg <= 1'b0;
            end
         endcase
      end
   end

   // Refused reads drop RVALID but leave the read data registers untouched.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rvalid_reg <= 1'b0;
         perr_reg   <= 1'b0;
         for (int p = 0; p < NPORTS; p++) begin
            rd_reg[p] <= '0;
         end
      end else begin
         rvalid_reg <= rd_acc;
         perr_reg   <= rd_acc & perr_next;
         if (rd_acc) begin
            for (int p = 0; p < NPORTS; p++) begin
               rd_reg[p] <= rd_next[p];
            end
         end
      end
   end

`ifdef VREG_PARITY_EN
   logic [NUM_REGS*LANES-1:0] par_reg;
   logic [LANES-1:0]          wb_par;
   logic [LANES-1:0]          wr_par_merged;
   logic [LANES-1:0]          par_err [NPORTS];

   genvar gj;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_wb_par
         assign wb_par[gi] = ^bus.WB[gi*LANE_W +: LANE_W];
      end
      // Stored parity goes through the same bypass as the data, so a forwarded lane checks clean.
      for (gi = 0; gi < NPORTS; gi++) begin : g_par_port
         logic [LANES-1:0] stored;
         logic [LANES-1:0] recomputed;
         assign stored = (wr_acc && (rd_idx[gi] == wr_idx)) ? wr_par_merged
                                                             : par_reg[rd_idx[gi]*LANES +: LANES];
         for (gj = 0; gj < LANES; gj++) begin : g_lane
            assign recomputed[gj] = ^rd_next[gi][gj*LANE_W +: LANE_W];
         end
         assign par_err[gi] = stored ^ recomputed;
      end
   endgenerate

   assign wr_par_merged = (par_reg[wr_idx*LANES +: LANES] & ~bus.WMASK) | (wb_par & bus.WMASK);
   assign perr_next     = (|par_err[0]) | (|par_err[1]);

   always_ff @(posedge CLK) begin
      if (RST) begin
         par_reg <= '0;
      end else if (clearing) begin
         par_reg[clr_idx*LANES +: LANES] <= '0;
      end else if (wr_acc) begin
         par_reg[wr_idx*LANES +: LANES] <= wr_par_merged;
      end
   end
`else
   assign perr_next = 1'b0;
`endif

   assign bus.RSTALL   = rstall;
   assign bus.RVALID   = rvalid_reg;
   assign bus.RD1      = rd_reg[0];
   assign bus.RD2      = rd_reg[1];
   assign bus.CLR_BUSY = clr_busy_reg;
   assign bus.CLR_DONE = clr_done_reg;
   assign bus.PERR     = perr_reg;

endmodule

// File: tb/tb_vreg_file.sv
// Directed bench for vreg_file: a spec-level model is checked every cycle, plus literal checks.
module tb_vreg_file;
   import vreg_pkg::*;

   localparam int DW = 256;
   localparam int LW = 32;
   localparam int NR = 8;
   localparam int AW = 5;
   localparam int NL = DW / LW;
   localparam int PH_IDLE = 0;
   localparam int PH_CLR  = 1;
   localparam int PH_DONE = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vreg_file_if #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW)) bus ();

   vreg_file #(.DATA_W(DW), .LANE_W(LW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_regs [NR];
   logic [NR-1:0] m_pend;
   int            m_phase;
   int            m_sweep;
   int            m_corrupt = -1;
   logic          m_rvalid;
   logic          m_perr;
   logic [DW-1:0] m_rd1;
   logic [DW-1:0] m_rd2;
   int            ma1, ma2, ma3;
   logic          m_stall, m_wr_ok;
   logic [DW-1:0] m_wv;

   function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                                input logic [NL-1:0] m);
      logic [DW-1:0] r;
      r = o;
      for (int l = 0; l < NL; l++) begin
         if (m[l]) r[l*LW +: LW] = n[l*LW +: LW];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NR; r++) m_regs[r] = '0;
         m_pend   = '0;
         m_phase  = PH_IDLE;
         m_sweep  = 0;
         m_rvalid = 1'b0;
         m_perr   = 1'b0;
         m_rd1    = '0;
         m_rd2    = '0;
      end else begin
         ma1     = int'(bus.A1[2:0]);
         ma2     = int'(bus.A2[2:0]);
         ma3     = int'(bus.A3[2:0]);
         m_stall = bus.RE && (m_phase == PH_CLR || m_pend[ma1] || m_pend[ma2]);
         m_wr_ok = bus.WE && (m_phase == PH_IDLE);
         m_wv    = lane_merge(m_regs[ma3], bus.WB, bus.WMASK);
         m_rvalid = bus.RE && !m_stall;
         if (m_rvalid) begin
            m_rd1  = (m_wr_ok && ma1 == ma3) ? m_wv : m_regs[ma1];
            m_rd2  = (m_wr_ok && ma2 == ma3) ? m_wv : m_regs[ma2];
            m_perr = (m_corrupt >= 0) && (ma1 == m_corrupt || ma2 == m_corrupt);
         end else begin
            m_perr = 1'b0;
         end
         case (m_phase)
            PH_IDLE: begin
               if (m_wr_ok) begin
                  m_regs[ma3] = m_wv;
                  m_pend[ma3] = 1'b0;
               end
               if (bus.CLR_REQ) begin
                  m_phase = PH_CLR;
                  m_sweep = 0;
               end
            end
            PH_CLR: begin
               m_regs[m_sweep] = '0;
               m_pend[m_sweep] = 1'b0;
               m_sweep++;
               if (m_sweep == NR) m_phase = PH_DONE;
            end
            default: m_phase = PH_IDLE;
         endcase
         if (bus.RSV) m_pend[ma3] = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rvalid",   DW'(bus.RVALID),   DW'(m_rvalid));
         chk("rd1",      bus.RD1,           m_rd1);
         chk("rd2",      bus.RD2,           m_rd2);
         chk("rstall",   DW'(bus.RSTALL),
             DW'(bus.RE && (m_phase == PH_CLR || m_pend[bus.A1[2:0]] || m_pend[bus.A2[2:0]])));
         chk("clr_busy", DW'(bus.CLR_BUSY), DW'(m_phase == PH_CLR));
         chk("clr_done", DW'(bus.CLR_DONE), DW'(m_phase == PH_DONE));
         chk("perr",     DW'(bus.PERR),     DW'(m_perr));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_in();
      bus.RE = 1'b0; bus.A1 = '0; bus.A2 = '0;
      bus.WE = 1'b0; bus.A3 = '0; bus.WMASK = '0; bus.WB = '0;
      bus.RSV = 1'b0; bus.CLR_REQ = 1'b0;
   endtask

   task automatic step(input string what);
      if (what != "") $display("[%0t] %s", $time, what);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [NL-1:0] m, input logic [DW-1:0] d);
      bus.WE = 1'b1; bus.A3 = AW'(a); bus.WMASK = m; bus.WB = d;
   endtask

   task automatic rd(input int a1, input int a2);
      bus.RE = 1'b1; bus.A1 = AW'(a1); bus.A2 = AW'(a2);
   endtask

   logic [DW-1:0] lit;
   logic [DW-1:0] pat_p, pat_q, pat_r;
   int busy_n, done_n;
`ifdef VREG_PARITY_EN
   logic [NR*NL-1:0] par_snap;
`endif

   initial begin
      rst = 1'b1;
      idle_in();
      step("reset");
      step("reset");
      rst = 1'b0;
      chk_en = 1'b1;

      // Read after reset.
      rd(0, 7); step("read A1=0 A2=7");
      idle_in();
      chk("t1_rvalid", DW'(bus.RVALID), DW'(1'b1));
      chk("t1_rd1", bus.RD1, '0);
      chk("t1_rd2", bus.RD2, '0);

      // Single-lane write then read.
      wr(3, 8'h01, {8{32'hA5A5A5A5}}); step("write r3 mask 01");
      idle_in();
      rd(3, 7); step("read A1=3 A2=7");
      idle_in();
      lit = '0; lit[31:0] = 32'hA5A5A5A5;
      chk("t2_rd1", bus.RD1, lit);

      // Full bypass on port 1 while port 2 reads another register.
      pat_p = {8{32'h1234_5678}};
      wr(2, 8'hFF, pat_p); rd(2, 3); step("write r2 mask FF + read A1=2 A2=3");
      idle_in();
      chk("t3_rd1", bus.RD1, pat_p);
      chk("t3_rd2", bus.RD2, lit);

      // Partial bypass on both ports reading the same index.
      wr(3, 8'h0A, {8{32'hDEADBEEF}}); rd(3, 3); step("write r3 mask 0A + read A1=A2=3");
      idle_in();
      lit = 256'h00000000_00000000_00000000_00000000_DEADBEEF_00000000_DEADBEEF_A5A5A5A5;
      chk("t3b_rd1", bus.RD1, lit);
      chk("t3b_rd2", bus.RD2, lit);

      // Reservation stalls reads until the write lands.
      bus.RSV = 1'b1; bus.A3 = AW'(5); step("reserve r5");
      idle_in();
      rd(5, 0); #1;
      chk("t4_rstall", DW'(bus.RSTALL), DW'(1'b1));
      step("read A1=5 (pending)");
      idle_in();
      chk("t4_rvalid0", DW'(bus.RVALID), DW'(1'b0));
      chk("t4_hold", bus.RD1, lit);
      pat_q = {8{32'h0BAD_F00D}};
      wr(5, 8'hFF, pat_q); step("write r5 mask FF");
      idle_in();
      rd(5, 5); #1;
      chk("t4_rstall0", DW'(bus.RSTALL), DW'(1'b0));
      step("read A1=A2=5");
      idle_in();
      chk("t4_rvalid1", DW'(bus.RVALID), DW'(1'b1));
      chk("t4_rd1", bus.RD1, pat_q);

      // Reserve and write together: reserve wins; an empty-mask write releases it.
      pat_r = {8{32'h5566_7788}};
      wr(6, 8'hFF, pat_r); bus.RSV = 1'b1; step("write+reserve r6");
      idle_in();
      rd(6, 6); #1;
      chk("t4b_rstall", DW'(bus.RSTALL), DW'(1'b1));
      step("read A1=A2=6 (pending)");
      idle_in();
      wr(6, 8'h00, '0); step("write r6 mask 00");
      idle_in();
      rd(6, 6); step("read A1=A2=6");
      idle_in();
      chk("t4b_rd1", bus.RD1, pat_r);

      // Fill, zeroize, and poke writes and requests during the sweep.
      for (int i = 0; i < NR; i++) begin
         wr(i, 8'hFF, {8{32'(32'h11111111 * (i + 1))}});
         step($sformatf("fill r%0d", i));
      end
      wr(0, 8'hFF, {8{32'hCAFEF00D}}); bus.CLR_REQ = 1'b1; step("write r0 + CLR_REQ");
      idle_in();
      busy_n = 0; done_n = 0;
      for (int k = 0; k < 12; k++) begin
         busy_n += int'(bus.CLR_BUSY);
         done_n += int'(bus.CLR_DONE);
         if (k < 8) begin
            wr(k, 8'hFF, '1);
            bus.CLR_REQ = 1'b1;
         end else begin
            idle_in();
         end
         step("");
      end
      idle_in();
      $display("[%0t] clear window: busy %0d cycles, done %0d pulses", $time, busy_n, done_n);
      chk("t5_busy_cycles", DW'(busy_n), DW'(8));
      chk("t5_done_pulses", DW'(done_n), DW'(1));
      for (int i = 0; i < NR; i += 2) begin
         rd(i, i + 1); step($sformatf("read A1=%0d A2=%0d after clear", i, i + 1));
         idle_in();
         chk("t5_rd1_zero", bus.RD1, '0);
         chk("t5_rd2_zero", bus.RD2, '0);
      end

      // Reset in the third cycle of a sweep.
      wr(2, 8'hFF, pat_p); step("write r2");
      wr(3, 8'hFF, pat_q); step("write r3");
      wr(5, 8'hFF, pat_r); step("write r5");
      idle_in();
      bus.CLR_REQ = 1'b1; step("CLR_REQ");
      idle_in();
      step("");
      step("");
      rst = 1'b1; step("RST mid-clear");
      rst = 1'b0;
      chk("t6_busy", DW'(bus.CLR_BUSY), DW'(1'b0));
      chk("t6_done", DW'(bus.CLR_DONE), DW'(1'b0));
      chk("t6_rvalid", DW'(bus.RVALID), DW'(1'b0));
      for (int i = 0; i < NR; i += 2) begin
         rd(i, i + 1); step($sformatf("read A1=%0d A2=%0d after reset", i, i + 1));
         idle_in();
         chk("t6_rd1_zero", bus.RD1, '0);
         chk("t6_rd2_zero", bus.RD2, '0);
      end
      wr(4, 8'h81, {8{32'h0F0F0F0F}}); step("write r4 mask 81");
      idle_in();
      rd(4, 4); step("read A1=A2=4");
      idle_in();
      lit = 256'h0F0F0F0F_00000000_00000000_00000000_00000000_00000000_00000000_0F0F0F0F;
      chk("t6_rd1", bus.RD1, lit);

`ifdef VREG_PARITY_EN
      // Flip one stored parity bit of r4 lane 0 and read it back.
      par_snap = dut.par_reg;
      force dut.par_reg = par_snap ^ (64'd1 << (4 * NL));
      m_corrupt = 4;
      rd(4, 0); step("read A1=4 with flipped parity");
      idle_in();
      chk("t7_perr", DW'(bus.PERR), DW'(1'b1));
      release dut.par_reg;
      m_corrupt = -1;
      wr(4, 8'hFF, '0); step("rewrite r4");
      idle_in();
`endif

      step("");
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
